io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_64b, selecting data/address width DW = 1<<(XLEN+4).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port i_io_en  input  1  IO region select from the address mapper.
REQ-005 SHALL have port i_addr  input  DW  mapper-translated offset within the IO region.
REQ-006 SHALL have port i_rd  input  1  load request.
REQ-007 SHALL have port i_wr  input  1  store request.
REQ-008 SHALL have port i_wdata  input  DW  store data.
REQ-009 SHALL have port i_resp_ready  input  1  requester accepts the response.
REQ-010 SHALL have port o_busy  output  1  high while a response is pending; new requests are ignored.
REQ-011 SHALL have port o_resp_valid  output  1  response present.
REQ-012 SHALL have port o_rdata  output  DW  load data, valid with o_resp_valid.
REQ-013 SHALL have port o_err  output  1  access fault, valid with o_resp_valid.
REQ-014 SHALL have port o_irq  output  1  timer compare interrupt.

Function
REQ-015 SHALL implement an FSM with states IDLE and RESP; o_busy = o_resp_valid = (state==RESP).
REQ-016 SHALL accept a request in IDLE when i_io_en && (i_rd || i_wr), moving to RESP on the next edge; other inputs in IDLE have no effect.
REQ-017 SHALL hold o_rdata/o_err stable in RESP and return to IDLE on the edge where i_resp_ready=1; requests arriving in RESP are dropped.
REQ-018 SHALL decode register index = i_addr / (DW/8); stride DW/8 bytes: 0 CTRL, 1 STATUS, 2 TIMER, 3 COMPARE, 4 SCRATCH.
REQ-019 SHALL flag o_err and perform no write for: i_addr not a multiple of DW/8, index > 4, or i_rd && i_wr together; o_rdata = 0 on error.
REQ-020 SHALL define CTRL bit0 = timer enable, bit1 = irq enable; other bits read 0.
REQ-021 SHALL define STATUS bit0 = compare-match pending, sticky, write-1-to-clear; writing 0 has no effect.
REQ-022 SHALL increment TIMER by 1 per cycle while CTRL[0]=1, wrapping all-ones to 0.
REQ-023 SHALL give a store to TIMER priority over the increment in the same cycle.
REQ-024 SHALL set pending on any cycle where the registered TIMER equals COMPARE and CTRL[0]=1; a set in the same cycle as a W1C clear wins.
REQ-025 SHALL commit stores on the accepting edge; loads capture register value at the accepting edge into o_rdata.
REQ-026 SHALL provide SCRATCH as a plain DW-bit read/write register.

Reset
REQ-027 SHALL, on i_rst_n=0 at a clock edge, set state IDLE, CTRL=0, STATUS=0, TIMER=0, COMPARE=all-ones, SCRATCH=0, o_rdata=0, o_err=0.
REQ-028 SHALL abandon an outstanding response on reset mid-RESP; o_resp_valid=0 the cycle after.

Configuration
REQ-029 SHALL, with IO_TIMER_IRQ_EN defined, drive o_irq = STATUS[0] & CTRL[1] (registered-state combinational).
REQ-030 SHALL, without IO_TIMER_IRQ_EN, tie o_irq=0, make CTRL[1] read 0 and ignore writes to it; STATUS[0] still functions.

Verification
REQ-031 Reset then load index 3 (addr 0x18, DW=64) with i_resp_ready=1 -> one-cycle o_resp_valid, o_rdata=0xFFFF_FFFF_FFFF_FFFF, o_err=0.
REQ-032 Store SCRATCH=0xDEADBEEF, hold i_resp_ready=0 for 3 cycles while issuing another store -> o_busy high 4 cycles, second store dropped, readback 0xDEADBEEF.
REQ-033 Store COMPARE=5, CTRL=0x3 -> STATUS[0]=1 and o_irq=1 (macro defined) after TIMER reaches 5; store STATUS=1 -> o_irq=0.
REQ-034 Load addr 0x04, load addr 0x28, simultaneous rd+wr to SCRATCH -> each o_err=1, o_rdata=0, SCRATCH unchanged.
REQ-035 Store TIMER=all-ones with CTRL[0]=1 -> next cycle TIMER=0; store TIMER=100 while counting -> TIMER reads 100 + elapsed cycles.
REQ-036 Assert i_rst_n=0 during RESP -> o_resp_valid=0 next cycle, all registers at REQ-027 values; build without macro -> o_irq stays 0 across REQ-033.

Source files
------------

// File: rtl/io_responder.sv
// Memory-mapped IO responder: CTRL/STATUS/TIMER/COMPARE/SCRATCH with a single-outstanding response.
// Optional timer interrupt output enabled by defining IO_TIMER_IRQ_EN.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module io_responder #(
    parameter int XLEN = `XLEN_64b,
    parameter int DW   = 1 << (XLEN + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_io_en,
    input  logic [DW-1:0] i_addr,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_resp_ready,
    output logic          o_busy,
    output logic          o_resp_valid,
    output logic [DW-1:0] o_rdata,
    output logic          o_err,
    output logic          o_irq
);
    localparam int AW = $clog2(DW / 8);

    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nx;

    logic          tmr_en, irq_en, pending, match, acc, bad, wr_ok;
    logic [DW-1:0] timer, compare, scratch, idx, rd_val;
    logic [2:0]    sel;
    logic [4:0]    wsel;

    assign acc   = (state == IDLE) && i_io_en && (i_rd || i_wr);
    assign idx   = i_addr >> AW;
    assign sel   = i_addr[AW+2:AW];
    assign bad   = (|i_addr[AW-1:0]) || (idx > DW'(4)) || (i_rd && i_wr);
    assign wr_ok = acc && i_wr && !bad;
    assign match = tmr_en && (timer == compare);

    always_comb begin
        wsel = '0;
        if (wr_ok) wsel[sel] = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            3'd0:    rd_val = {{(DW-2){1'b0}}, irq_en, tmr_en};
            3'd1:    rd_val = {{(DW-1){1'b0}}, pending};
            3'd2:    rd_val = timer;
            3'd3:    rd_val = compare;
            3'd4:    rd_val = scratch;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        o_busy       = 1'b0;
        o_resp_valid = 1'b0;
        case (state)
            IDLE: if (acc) state_nx = RESP;
            RESP: begin
                o_busy       = 1'b1;
                o_resp_valid = 1'b1;
                if (i_resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            tmr_en  <= 1'b0;
            pending <= 1'b0;
            timer   <= '0;
            compare <= '1;
            scratch <= '0;
            o_rdata <= '0;
            o_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (wsel[0]) tmr_en <= i_wdata[0];
            // A compare match in the same cycle beats a W1C clear.
            pending <= match | (pending & ~(wsel[1] & i_wdata[0]));
            if (wsel[2])     timer <= i_wdata;
            else if (tmr_en) timer <= timer + DW'(1);
            if (wsel[3]) compare <= i_wdata;
            if (wsel[4]) scratch <= i_wdata;
            if (acc) begin
                o_err   <= bad;
                o_rdata <= (bad || !i_rd) ? '0 : rd_val;
            end
        end
    end

`ifdef IO_TIMER_IRQ_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)     irq_en <= 1'b0;
        else if (wsel[0]) irq_en <= i_wdata[1];
    end
    assign o_irq = pending & irq_en;
`else
    assign irq_en = 1'b0;
    assign o_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Randomized and directed bench for io_responder against a cycle-level register model.
module tb_io_responder;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_io_en = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
    logic        i_resp_ready = 1'b0;
    logic [63:0] i_addr = '0, i_wdata = '0;
    logic        o_busy, o_resp_valid, o_err, o_irq;
    logic [63:0] o_rdata;

    int checks = 0, errors = 0;

    io_responder dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_io_en(i_io_en), .i_addr(i_addr),
        .i_rd(i_rd), .i_wr(i_wr), .i_wdata(i_wdata), .i_resp_ready(i_resp_ready),
        .o_busy(o_busy), .o_resp_valid(o_resp_valid), .o_rdata(o_rdata),
        .o_err(o_err), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

`ifdef IO_TIMER_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    // Reference model state
    logic        m_busy, m_err, m_te, m_ie, m_pend;
    logic [63:0] m_rdata, m_timer, m_cmp, m_scratch;

    function automatic logic [63:0] mread(input logic [63:0] idx);
        case (idx)
            64'd0:   return {62'd0, m_ie, m_te};
            64'd1:   return {63'd0, m_pend};
            64'd2:   return m_timer;
            64'd3:   return m_cmp;
            64'd4:   return m_scratch;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_pend && m_ie && IRQ_BUILT;
    endfunction

    // Advance one clock: model computes the effect of the current inputs, then the DUT clocks.
    task automatic tick();
        logic        n_busy, n_err, n_te, n_ie, n_pend, acc, er, hit;
        logic [63:0] n_rdata, n_timer, n_cmp, n_scratch, idx;
        n_busy = m_busy; n_err = m_err; n_te = m_te; n_ie = m_ie; n_pend = m_pend;
        n_rdata = m_rdata; n_timer = m_timer; n_cmp = m_cmp; n_scratch = m_scratch;
        if (!i_rst_n) begin
            n_busy = 0; n_err = 0; n_te = 0; n_ie = 0; n_pend = 0;
            n_rdata = 0; n_timer = 0; n_cmp = '1; n_scratch = 0;
        end else begin
            acc = !m_busy && i_io_en && (i_rd || i_wr);
            hit = m_te && (m_timer == m_cmp);
            if (m_busy && i_resp_ready) n_busy = 0;
            if (m_te) n_timer = m_timer + 64'd1;
            if (hit) n_pend = 1;
            if (acc) begin
                idx = i_addr / 8;
                er = (i_addr % 8 != 0) || (idx > 4) || (i_rd && i_wr);
                n_busy = 1; n_err = er;
                n_rdata = (er || !i_rd) ? 64'd0 : mread(idx);
                if (!er && i_wr) begin
                    case (idx)
                        64'd0: begin n_te = i_wdata[0]; n_ie = i_wdata[1] && IRQ_BUILT; end
                        64'd1: if (i_wdata[0] && !hit) n_pend = 0;
                        64'd2: n_timer = i_wdata;
                        64'd3: n_cmp = i_wdata;
                        64'd4: n_scratch = i_wdata;
                        default: ;
                    endcase
                end
            end
        end
        @(posedge i_clk);
        #1;
        m_busy = n_busy; m_err = n_err; m_te = n_te; m_ie = n_ie; m_pend = n_pend;
        m_rdata = n_rdata; m_timer = n_timer; m_cmp = n_cmp; m_scratch = n_scratch;
    endtask

    // One request; ready is withheld for dly response cycles; optional store spam while busy.
    task automatic access(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                          input int dly, input logic spam,
                          output logic [63:0] rdat, output logic er,
                          output logic [63:0] e_rdat, output logic e_er, output int bcyc);
        i_io_en = 1; i_rd = rd; i_wr = wr; i_addr = a; i_wdata = wd; i_resp_ready = 0;
        tick();
        e_rdat = m_rdata; e_er = m_err;
        i_io_en = spam; i_rd = 0; i_wr = spam; i_addr = 64'h20; i_wdata = 64'h5555_AAAA;
        bcyc = 0; rdat = 'x; er = 1'bx;
        while (o_busy && bcyc < 100) begin
            rdat = o_rdata; er = o_err; bcyc++;
            i_resp_ready = (bcyc > dly);
            tick();
        end
        i_io_en = 0; i_wr = 0; i_resp_ready = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_io_en = 0; i_rd = 0; i_wr = 0; i_resp_ready = 0;
        tick(); tick();
        i_rst_n = 1;
    endtask

    task automatic test_reset();
        logic [63:0] rd, erd, exp_v[5];
        logic er, eer; int b;
        exp_v = '{64'd0, 64'd0, 64'd0, '1, 64'd0};
        do_reset();
        checks++;
        if (o_busy !== 0 || o_resp_valid !== 0 || o_irq !== 0 || o_rdata !== 0 || o_err !== 0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b irq=%b rdata=%h err=%b, required all 0",
                     o_busy, o_resp_valid, o_irq, o_rdata, o_err);
        end
        for (int k = 0; k < 5; k++) begin
            access(1, 0, 64'(k * 8), 0, 0, 0, rd, er, erd, eer, b);
            checks++;
            if (rd !== exp_v[k] || er !== 0 || b != 1) begin
                errors++;
                $display("FAIL reset_reg%0d: rdata=%h err=%b busy_cycles=%0d, required %h 0 1",
                         k, rd, er, b, exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd, erd; logic er, eer; int b;
        do_reset();
        access(0, 1, 64'h20, 64'hDEADBEEF, 3, 1, rd, er, erd, eer, b);
        checks++;
        if (b != 4 || er !== 0) begin
            errors++;
            $display("FAIL backpressure_busy: busy_cycles=%0d err=%b, required 4 0", b, er);
        end
        access(1, 0, 64'h20, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== 64'hDEADBEEF || er !== 0) begin
            errors++;
            $display("FAIL dropped_store: scratch=%h err=%b, required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_timer_irq();
        logic [63:0] rd, erd; logic er, eer; int b;
        do_reset();
        access(0, 1, 64'h18, 64'd5, 0, 0, rd, er, erd, eer, b);
        access(0, 1, 64'h00, 64'h3, 0, 0, rd, er, erd, eer, b);
        repeat (10) tick();
        checks++;
        if (o_irq !== IRQ_BUILT) begin
            errors++;
            $display("FAIL irq_set: o_irq=%b, required %b", o_irq, IRQ_BUILT);
        end
        access(1, 0, 64'h08, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== 64'd1) begin
            errors++;
            $display("FAIL status_pending: status=%h, required 1", rd);
        end
        access(1, 0, 64'h00, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== {62'd0, IRQ_BUILT, 1'b1}) begin
            errors++;
            $display("FAIL ctrl_read: ctrl=%h, required %h", rd, {62'd0, IRQ_BUILT, 1'b1});
        end
        access(0, 1, 64'h08, 64'd1, 0, 0, rd, er, erd, eer, b);
        access(1, 0, 64'h08, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (o_irq !== 0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL status_clear: o_irq=%b status=%h, required 0 0", o_irq, rd);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd, erd, a[3]; logic er, eer; int b;
        logic rr[3], ww[3];
        a = '{64'h04, 64'h28, 64'h20};
        rr = '{1, 1, 1}; ww = '{0, 0, 1};
        do_reset();
        access(0, 1, 64'h20, 64'h1234, 0, 0, rd, er, erd, eer, b);
        for (int k = 0; k < 3; k++) begin
            access(rr[k], ww[k], a[k], 64'hFFFF, 0, 0, rd, er, erd, eer, b);
            checks++;
            if (er !== 1 || rd !== 0) begin
                errors++;
                $display("FAIL access_fault%0d: err=%b rdata=%h, required 1 0", k, er, rd);
            end
        end
        access(1, 0, 64'h20, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== 64'h1234) begin
            errors++;
            $display("FAIL fault_no_write: scratch=%h, required 1234", rd);
        end
    endtask

    task automatic test_timer_wrap();
        logic [63:0] rd, erd; logic er, eer; int b;
        do_reset();
        access(0, 1, 64'h00, 64'h1, 0, 0, rd, er, erd, eer, b);
        access(0, 1, 64'h10, '1, 0, 0, rd, er, erd, eer, b);
        access(1, 0, 64'h10, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== 64'd0) begin
            errors++;
            $display("FAIL timer_wrap: timer=%h, required 0", rd);
        end
        access(0, 1, 64'h10, 64'd100, 0, 0, rd, er, erd, eer, b);
        access(1, 0, 64'h10, 0, 0, 0, rd, er, erd, eer, b);
        checks++;
        if (rd !== 64'd101) begin
            errors++;
            $display("FAIL timer_store_priority: timer=%0d, required 101", rd);
        end
    endtask

    task automatic test_reset_mid_resp();
        logic [63:0] rd, erd, exp_v[5]; logic er, eer; int b;
        exp_v = '{64'd0, 64'd0, 64'd0, '1, 64'd0};
        do_reset();
        access(0, 1, 64'h00, 64'h3, 0, 0, rd, er, erd, eer, b);
        access(0, 1, 64'h18, 64'd2, 0, 0, rd, er, erd, eer, b);
        i_io_en = 1; i_wr = 1; i_addr = 64'h20; i_wdata = 64'hCAFE;
        tick();
        i_io_en = 0; i_wr = 0;
        checks++;
        if (o_resp_valid !== 1) begin
            errors++;
            $display("FAIL pre_reset_valid: valid=%b, required 1", o_resp_valid);
        end
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
        checks++;
        if (o_resp_valid !== 0 || o_busy !== 0 || o_irq !== 0) begin
            errors++;
            $display("FAIL reset_mid_resp: valid=%b busy=%b irq=%b, required 0 0 0",
                     o_resp_valid, o_busy, o_irq);
        end
        for (int k = 0; k < 5; k++) begin
            access(1, 0, 64'(k * 8), 0, 0, 0, rd, er, erd, eer, b);
            checks++;
            if (rd !== exp_v[k] || er !== 0) begin
                errors++;
                $display("FAIL post_reset_reg%0d: rdata=%h err=%b, required %h 0", k, rd, er, exp_v[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, a, wd; logic er, eer, r, w; int b, op, dly;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                i_io_en = 0; i_rd = 1; i_wr = $urandom_range(0, 1);
                tick();
                i_rd = 0; i_wr = 0;
                checks++;
                if (o_busy !== m_busy) begin
                    errors++;
                    $display("FAIL rand_no_io_en: busy=%b, required %b", o_busy, m_busy);
                end
            end
            op = $urandom_range(0, 9);
            r = (op < 5) || (op == 9);
            w = (op >= 5);
            case ($urandom_range(0, 5))
                0:       a = 64'($urandom_range(0, 47));
                1:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 4) * 8);
            endcase
            wd = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
            dly = $urandom_range(0, 3);
            access(r, w, a, wd, dly, $urandom_range(0, 1), rd, er, erd, eer, b);
            checks++;
            if (er !== eer || ((r || eer) && rd !== erd) || b != dly + 1) begin
                errors++;
                $display("FAIL rand_access%0d: addr=%h rd=%b wr=%b rdata=%h err=%b cycles=%0d, required %h %b %0d",
                         n, a, r, w, rd, er, b, erd, eer, dly + 1);
            end
            checks++;
            if (o_irq !== model_irq()) begin
                errors++;
                $display("FAIL rand_irq%0d: o_irq=%b, required %b", n, o_irq, model_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_timer_irq();
        test_errors();
        test_timer_wrap();
        test_reset_mid_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
